// File: rtl/macro_arbiter_rr_bin_pkg.sv
// Shared definitions for the round-robin binary arbiter: pick priority selectors
// and the arbiter FSM state encoding.
package macro_arbiter_rr_bin_pkg;

    localparam int PRIORITY_LOWER_FIRST  = 0;
    localparam int PRIORITY_HIGHER_FIRST = 1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/macro_arbiter_rr_mask.sv
// Round-robin priority mask: thermometer code with every bit at or above the
// pointer set. Purely combinational.
module macro_arbiter_rr_mask #(
    parameter int INPUT_COUNT = 4,
    parameter int PTR_W       = $clog2(INPUT_COUNT)
) (
    input  logic [PTR_W-1:0]       pointer,
    output logic [INPUT_COUNT-1:0] mask
);

    generate
        for (genvar gi = 0; gi < INPUT_COUNT; gi++) begin : g_mask
            assign mask[gi] = (PTR_W'(gi) >= pointer);
        end
    endgenerate

endmodule

// File: rtl/macro_pick1_priority_bin.sv
// Pick-one priority selector: returns the binary index of the lowest (or highest)
// set request bit, plus a found flag.
module macro_pick1_priority_bin
    import macro_arbiter_rr_bin_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRIORITY = PRIORITY_LOWER_FIRST,
    parameter int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        if (PRIORITY == PRIORITY_LOWER_FIRST) begin
            // Scan downward so the last hit written is the lowest set bit.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    found = 1'b1;
                    idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    found = 1'b1;
                    idx   = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/macro_arbiter_rr_bin.sv
// Registered round-robin arbiter with binary grant and valid/ready handshake.
// Optional MACRO_ARBITER_RR_LOCK_EN adds a lock input for burst ownership.
module macro_arbiter_rr_bin
    import macro_arbiter_rr_bin_pkg::*;
#(
    parameter int INPUT_COUNT = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [INPUT_COUNT-1:0]         req,
    input  logic                           gnt_ready,
`ifdef MACRO_ARBITER_RR_LOCK_EN
    input  logic                           lock,
`endif
    output logic                           gnt_valid,
    output logic [$clog2(INPUT_COUNT)-1:0] gnt_addr,
    output logic [INPUT_COUNT-1:0]         gnt_onehot
);

    localparam int ADDR_W = $clog2(INPUT_COUNT);

    arb_state_e              state_reg, state_next;
    logic [ADDR_W-1:0]       addr_reg, addr_next;
    logic [ADDR_W-1:0]       ptr_reg, ptr_next;
    logic [ADDR_W-1:0]       ptr_adv;
    logic [ADDR_W-1:0]       mask_ptr;
    logic [INPUT_COUNT-1:0]  mask;
    logic                    masked_found, unmasked_found;
    logic [ADDR_W-1:0]       masked_idx, unmasked_idx;
    logic [ADDR_W-1:0]       pick;
    logic                    accept;
    logic                    lock_accept;

    assign accept = (state_reg == ARB_GRANT) && gnt_ready;

`ifdef MACRO_ARBITER_RR_LOCK_EN
    assign lock_accept = accept && lock;
`else
    assign lock_accept = 1'b0;
`endif

    // Explicit wrap keeps the pointer in range when INPUT_COUNT is not a power of two.
    assign ptr_adv  = (addr_reg == ADDR_W'(INPUT_COUNT - 1)) ? '0 : addr_reg + 1'b1;
    // Back-to-back grants must already see the rotated priority.
    assign mask_ptr = (accept && !lock_accept) ? ptr_adv : ptr_reg;

    macro_arbiter_rr_mask #(
        .INPUT_COUNT (INPUT_COUNT),
        .PTR_W       (ADDR_W)
    ) u_mask (
        .pointer (mask_ptr),
        .mask    (mask)
    );

    macro_pick1_priority_bin #(
        .WIDTH    (INPUT_COUNT),
        .PRIORITY (PRIORITY_LOWER_FIRST),
        .IDX_W    (ADDR_W)
    ) u_pick_masked (
        .req   (req & mask),
        .found (masked_found),
        .idx   (masked_idx)
    );

    macro_pick1_priority_bin #(
        .WIDTH    (INPUT_COUNT),
        .PRIORITY (PRIORITY_LOWER_FIRST),
        .IDX_W    (ADDR_W)
    ) u_pick_unmasked (
        .req   (req),
        .found (unmasked_found),
        .idx   (unmasked_idx)
    );

    assign pick = masked_found ? masked_idx : unmasked_idx;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        ptr_next   = ptr_reg;
        if (accept && !lock_accept) begin
            ptr_next = ptr_adv;
        end
        case (state_reg)
            ARB_IDLE: begin
                if (unmasked_found) begin
                    addr_next  = pick;
                    state_next = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (accept) begin
                    if (lock_accept && req[addr_reg]) begin
                        addr_next = addr_reg;
                    end else if (unmasked_found) begin
                        addr_next = pick;
                    end else begin
                        addr_next  = '0;
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: begin
                addr_next  = '0;
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ARB_IDLE;
            addr_reg  <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign gnt_valid = (state_reg == ARB_GRANT);
    assign gnt_addr  = addr_reg;

    generate
        for (genvar gi = 0; gi < INPUT_COUNT; gi++) begin : g_onehot
            assign gnt_onehot[gi] = gnt_valid && (addr_reg == ADDR_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_macro_arbiter_rr_bin.sv
// Directed bench for macro_arbiter_rr_bin (INPUT_COUNT=4 and INPUT_COUNT=3 instances).
// Build with MACRO_ARBITER_RR_LOCK_EN defined to also cover the lock feature.
`timescale 1ns/1ps
module tb_macro_arbiter_rr_bin;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] req4;
    logic       ready4;
    logic       valid4;
    logic [1:0] addr4;
    logic [3:0] onehot4;
    logic [2:0] req3;
    logic       ready3;
    logic       valid3;
    logic [1:0] addr3;
    logic [2:0] onehot3;
    logic       lock;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    macro_arbiter_rr_bin #(.INPUT_COUNT(4)) dut4 (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req4),
        .gnt_ready  (ready4),
`ifdef MACRO_ARBITER_RR_LOCK_EN
        .lock       (lock),
`endif
        .gnt_valid  (valid4),
        .gnt_addr   (addr4),
        .gnt_onehot (onehot4)
    );

    macro_arbiter_rr_bin #(.INPUT_COUNT(3)) dut3 (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req3),
        .gnt_ready  (ready3),
`ifdef MACRO_ARBITER_RR_LOCK_EN
        .lock       (1'b0),
`endif
        .gnt_valid  (valid3),
        .gnt_addr   (addr3),
        .gnt_onehot (onehot3)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end else begin
            $display("ok   %s val=%0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant4(input string tag, input int v, input int a);
        int oh;
        oh = v ? (1 << a) : 0;
        chk({tag, ".valid"},  int'(valid4),  v);
        chk({tag, ".addr"},   int'(addr4),   a);
        chk({tag, ".onehot"}, int'(onehot4), oh);
    endtask

    initial begin
        int rot_exp[5];
        int n3_exp[4];
        rot_exp = '{1, 2, 3, 0, 1};
        n3_exp  = '{0, 1, 2, 0};

        resetn = 1'b0;
        req4   = 4'b1111;
        ready4 = 1'b0;
        req3   = 3'b000;
        ready3 = 1'b0;
        lock   = 1'b0;

        // Reset with all requests: everything stays cleared.
        tick();
        tick();
        chk_grant4("rst", 0, 0);
        req4   = 4'b0000;
        resetn = 1'b1;
        tick();
        tick();
        chk("idle.valid", int'(valid4), 0);
        ready4 = 1'b1;
        tick();
        chk("idle_ready.valid", int'(valid4), 0);
        ready4 = 1'b0;

        // One-cycle latency, hold while not ready, req drop does not revoke.
        req4 = 4'b0100;
        tick();
        chk_grant4("lat", 1, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req4 = 4'b0000;
            tick();
            chk_grant4($sformatf("hold%0d", i), 1, 2);
        end
        ready4 = 1'b1;
        tick();
        chk("acc_idle.valid", int'(valid4), 0);
        ready4 = 1'b0;

        // Pointer now 3: grant 3, wrap to 1, then mask fallback re-grants 1.
        req4 = 4'b1000;
        tick();
        chk_grant4("g3", 1, 3);
        req4   = 4'b1010;
        ready4 = 1'b1;
        tick();
        chk_grant4("wrap", 1, 1);
        req4 = 4'b0010;
        tick();
        chk_grant4("regrant", 1, 1);
        req4 = 4'b0000;
        tick();
        chk("drain.valid", int'(valid4), 0);
        ready4 = 1'b0;

        // Pointer now 2: grant 2, then asynchronous reset mid-grant.
        req4 = 4'b0100;
        tick();
        chk_grant4("pre_rst", 1, 2);
        #1 resetn = 1'b0;
        #1;
        chk_grant4("async_rst", 0, 0);
        req4 = 4'b1111;
        #1 resetn = 1'b1;
        tick();
        chk_grant4("post_rst", 1, 0);

        // Continuous rotation with gnt_valid held high.
        ready4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_grant4($sformatf("rot%0d", i), 1, rot_exp[i]);
        end

`ifdef MACRO_ARBITER_RR_LOCK_EN
        // Locked accept of grant 1 keeps ownership; unlocked accept rotates.
        lock = 1'b1;
        tick();
        chk_grant4("lock", 1, 1);
        lock = 1'b0;
        tick();
        chk_grant4("unlock", 1, 2);
`endif
        ready4 = 1'b0;
        req4   = 4'b0000;

        // Non-power-of-two instance wraps 2 -> 0.
        req3   = 3'b111;
        ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("n3_%0d.valid", i), int'(valid3), 1);
            chk($sformatf("n3_%0d.addr", i), int'(addr3), n3_exp[i]);
            chk($sformatf("n3_%0d.onehot", i), int'(onehot3), 1 << n3_exp[i]);
        end
        ready3 = 1'b0;
        req3   = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
